// File: rtl/range_scan_ctrl.sv
// Range-scan initiator: walks the local descriptor bank through an external combinational
// range evaluator and streams each matching cell out over a valid/ready port.
module range_scan_ctrl #(
  parameter int DATA_W  = 8,
  parameter int N_CELLS = 8,
  parameter int IDX_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cell_we,
  input  logic [IDX_W-1:0]  cell_addr,
  input  logic              cell_elt_def,
  input  logic              cell_is_meta,
  input  logic [DATA_W-1:0] cell_meta,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_handle,
  input  logic [DATA_W-1:0] req_low,
  input  logic [DATA_W-1:0] req_high,
  output logic [DATA_W-1:0] ev_handle,
  output logic [DATA_W-1:0] ev_low,
  output logic [DATA_W-1:0] ev_high,
  output logic              ev_elt_def,
  output logic              ev_is_meta,
  output logic [DATA_W-1:0] ev_meta,
  input  logic              ev_result_bool,
  input  logic [DATA_W-1:0] ev_result_value,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_value,
  output logic              busy,
  output logic              done,
  output logic [IDX_W:0]    match_count
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  handle_q, handle_d;
  logic [DATA_W-1:0]  low_q, low_d;
  logic [DATA_W-1:0]  high_q, high_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]   outIndex_q, outIndex_d;
  logic [DATA_W-1:0]  outValue_q, outValue_d;
  logic [IDX_W:0]     matchCount_q, matchCount_d;

  logic               eltDef_q [N_CELLS];
  logic               isMeta_q [N_CELLS];
  logic [DATA_W-1:0]  meta_q   [N_CELLS];

  // Descriptor bank; only writable while no scan is in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CELLS; i++) begin
        eltDef_q[i] <= 1'b0;
        isMeta_q[i] <= 1'b0;
        meta_q[i]   <= '0;
      end
    end else if (cell_we && state_q == IDLE) begin
      eltDef_q[cell_addr] <= cell_elt_def;
      isMeta_q[cell_addr] <= cell_is_meta;
      meta_q[cell_addr]   <= cell_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      handle_q     <= '0;
      low_q        <= '0;
      high_q       <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
      outIndex_q   <= '0;
      outValue_q   <= '0;
      matchCount_q <= '0;
    end else begin
      state_q      <= state_d;
      handle_q     <= handle_d;
      low_q        <= low_d;
      high_q       <= high_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      outIndex_q   <= outIndex_d;
      outValue_q   <= outValue_d;
      matchCount_q <= matchCount_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    handle_d     = handle_q;
    low_d        = low_q;
    high_d       = high_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    outIndex_d   = outIndex_q;
    outValue_d   = outValue_q;
    matchCount_d = matchCount_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          handle_d = req_handle;
          low_d    = req_low;
          high_d   = req_high;
          idx_d    = '0;
          cnt_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (ev_result_bool) begin
          outIndex_d = idx_q;
          outValue_d = ev_result_value;
          cnt_d      = cnt_q + 1'b1;
          state_d    = EMIT;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      EMIT: begin
        // The record is frozen here until downstream takes it.
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        matchCount_d = cnt_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state_q == IDLE) && rst_n;
    busy        = (state_q != IDLE);
    done        = (state_q == DONE);
    out_valid   = (state_q == EMIT);
    out_index   = outIndex_q;
    out_value   = outValue_q;
    match_count = matchCount_q;
    ev_handle   = handle_q;
    ev_low      = low_q;
    ev_high     = high_q;
    ev_elt_def  = eltDef_q[idx_q];
    ev_is_meta  = isMeta_q[idx_q];
    ev_meta     = meta_q[idx_q];
  end

endmodule

// File: tb/tb_range_scan_ctrl.sv
// Bench for range_scan_ctrl: a behavioural evaluator plus a bank/query reference model
// predicts the emitted records, match count and done latency for directed and random scans.
module tb_range_scan_ctrl;

  localparam int DW = 8;
  localparam int N  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cell_we;
  logic [IW-1:0] cell_addr;
  logic          cell_elt_def;
  logic          cell_is_meta;
  logic [DW-1:0] cell_meta;
  logic          req_valid;
  logic          req_ready;
  logic [DW-1:0] req_handle, req_low, req_high;
  logic [DW-1:0] ev_handle, ev_low, ev_high, ev_meta;
  logic          ev_elt_def, ev_is_meta;
  logic          ev_result_bool;
  logic [DW-1:0] ev_result_value;
  logic          out_valid, out_ready;
  logic [IW-1:0] out_index;
  logic [DW-1:0] out_value;
  logic          busy, done;
  logic [IW:0]   match_count;

  int compared   = 0;
  int mismatched = 0;

  logic          mEltDef [N];
  logic          mIsMeta [N];
  logic [DW-1:0] mMeta   [N];
  int            lastCount = 0;

  always #5 clk = ~clk;

  // Stand-in evaluator: a cell matches when it is defined, carries metadata equal to the handle.
  assign ev_result_bool  = ev_elt_def && ev_is_meta && (ev_meta == ev_handle);
  assign ev_result_value = ev_result_bool ? ev_high : ev_low;

  range_scan_ctrl #(.DATA_W(DW), .N_CELLS(N), .IDX_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cell_we(cell_we), .cell_addr(cell_addr), .cell_elt_def(cell_elt_def),
    .cell_is_meta(cell_is_meta), .cell_meta(cell_meta),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_handle(req_handle), .req_low(req_low), .req_high(req_high),
    .ev_handle(ev_handle), .ev_low(ev_low), .ev_high(ev_high),
    .ev_elt_def(ev_elt_def), .ev_is_meta(ev_is_meta), .ev_meta(ev_meta),
    .ev_result_bool(ev_result_bool), .ev_result_value(ev_result_value),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_value(out_value),
    .busy(busy), .done(done), .match_count(match_count)
  );

  task automatic writeCell(input int a, input bit e, input bit m, input logic [DW-1:0] md);
    @(negedge clk);
    cell_we = 1'b1; cell_addr = IW'(a); cell_elt_def = e; cell_is_meta = m; cell_meta = md;
    @(negedge clk);
    cell_we = 1'b0;
    mEltDef[a] = e; mIsMeta[a] = m; mMeta[a] = md;
  endtask

  task automatic clearBank();
    for (int i = 0; i < N; i++) writeCell(i, 1'b0, 1'b0, 8'd0);
  endtask

  // Runs one query and checks every record, the done latency and the final match count.
  task automatic run_scan(input logic [DW-1:0] h, input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                          input int firstStall, input int stallPct, input bit busyWrite);
    int expIdx[$];
    int got, stalls, firstStalls, k;
    bit doneSeen, holding, rdy;
    logic [IW-1:0] heldIdx;
    logic [DW-1:0] heldVal;
    for (int i = 0; i < N; i++)
      if (mEltDef[i] && mIsMeta[i] && mMeta[i] == h) expIdx.push_back(i);
    got = 0; stalls = 0; firstStalls = 0; doneSeen = 0; holding = 0;
    heldIdx = '0; heldVal = '0;

    @(negedge clk);
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL req_ready_idle: got %0b want 1", req_ready);
    end
    req_valid = 1'b1; req_handle = h; req_low = lo; req_high = hi;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_handle = DW'($urandom); req_low = DW'($urandom); req_high = DW'($urandom);
    compared++;
    if (busy !== 1'b1 || ev_handle !== h || ev_low !== lo || ev_high !== hi) begin
      mismatched++;
      $display("[TB] FAIL query_latch: busy=%0b ev=%0d/%0d/%0d want 1 %0d/%0d/%0d",
               busy, ev_handle, ev_low, ev_high, h, lo, hi);
    end
    compared++;
    if (match_count !== (IW+1)'(lastCount)) begin
      mismatched++; $display("[TB] FAIL count_held: got %0d want %0d", match_count, lastCount);
    end
    if (busyWrite) begin
      cell_we = 1'b1; cell_addr = 3'd1; cell_elt_def = 1'b0; cell_is_meta = 1'b0; cell_meta = 8'd0;
    end

    for (k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) cell_we = 1'b0;
      if (done === 1'b1) begin
        doneSeen = 1;
        break;
      end
      if (out_valid === 1'b1) begin
        if (holding) begin
          compared++;
          if (out_index !== heldIdx || out_value !== heldVal) begin
            mismatched++;
            $display("[TB] FAIL record_stable: got %0d/%0d want %0d/%0d", out_index, out_value, heldIdx, heldVal);
          end
        end
        if (got == 0 && firstStalls < firstStall) begin
          rdy = 1'b0; firstStalls++;
        end else begin
          rdy = ($urandom_range(99) >= stallPct);
        end
        if (!rdy) begin
          stalls++; holding = 1; heldIdx = out_index; heldVal = out_value;
        end else begin
          compared++;
          if (got >= expIdx.size() || out_index !== IW'(expIdx[got]) || out_value !== hi) begin
            mismatched++;
            $display("[TB] FAIL record_%0d: got idx %0d val %0d want idx %0d val %0d", got,
                     out_index, out_value, (got < expIdx.size()) ? expIdx[got] : -1, hi);
          end
          got++; holding = 0;
        end
        out_ready = rdy;
      end else begin
        holding = 0;
        out_ready = 1'($urandom_range(1));
      end
    end
    out_ready = 1'b0;

    compared++;
    if (!doneSeen) begin
      mismatched++; $display("[TB] FAIL done_timeout: no done within 200 cycles, want 1");
    end else if (k != N + expIdx.size() + stalls) begin
      mismatched++;
      $display("[TB] FAIL done_latency: got %0d want %0d", k + 1, N + expIdx.size() + stalls + 1);
    end
    compared++;
    if (got != expIdx.size()) begin
      mismatched++; $display("[TB] FAIL record_total: got %0d want %0d", got, expIdx.size());
    end
    @(negedge clk);
    compared++;
    if (match_count !== (IW+1)'(expIdx.size()) || done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL scan_end: count=%0d done=%0b busy=%0b want %0d 0 0",
               match_count, done, busy, expIdx.size());
    end
    lastCount = expIdx.size();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    compared++;
    if (req_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
        match_count !== '0 || ev_handle !== '0 || ev_meta !== '0 || ev_elt_def !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: rdy=%0b busy=%0b done=%0b ov=%0b cnt=%0d evh=%0d want all 0",
               req_ready, busy, done, out_valid, match_count, ev_handle);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL reset_release_ready: got %0b want 1", req_ready);
    end
    for (int i = 0; i < N; i++) begin mEltDef[i] = 0; mIsMeta[i] = 0; mMeta[i] = 0; end
    lastCount = 0;
  endtask

  task automatic test_no_match();
    for (int i = 0; i < N; i++) writeCell(i, 1'b0, 1'b1, 8'd3);
    run_scan(8'd3, 8'd1, 8'd2, 0, 0, 0);
  endtask

  task automatic test_single_match();
    clearBank();
    writeCell(5, 1'b1, 1'b1, 8'd3);
    run_scan(8'd3, 8'd10, 8'd20, 0, 0, 0);
  endtask

  task automatic test_backpressure();
    clearBank();
    writeCell(0, 1'b1, 1'b1, 8'd9);
    writeCell(7, 1'b1, 1'b1, 8'd9);
    run_scan(8'd9, 8'd4, 8'd77, 4, 0, 0);
  endtask

  task automatic test_all_match();
    for (int i = 0; i < N; i++) writeCell(i, 1'b1, 1'b1, 8'd2);
    run_scan(8'd2, 8'd5, 8'd99, 0, 30, 0);
  endtask

  task automatic test_write_while_busy();
    clearBank();
    writeCell(1, 1'b1, 1'b1, 8'd2);
    run_scan(8'd2, 8'd0, 8'd50, 0, 0, 1);
    run_scan(8'd2, 8'd0, 8'd51, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < N; i++)
        writeCell(i, ($urandom_range(3) != 0), ($urandom_range(3) != 0), DW'($urandom_range(3)));
      run_scan(DW'($urandom_range(3)), DW'($urandom), DW'($urandom), $urandom_range(2), 40, 0);
    end
  endtask

  task automatic test_reset_mid_emit();
    int w;
    clearBank();
    writeCell(0, 1'b1, 1'b1, 8'd5);
    @(negedge clk);
    req_valid = 1'b1; req_handle = 8'd5; req_low = 8'd1; req_high = 8'd2; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (w = 0; w < 20 && out_valid !== 1'b1; w++) @(negedge clk);
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++; $display("[TB] FAIL emit_reach: out_valid=%0b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || match_count !== '0 || done !== 1'b0 || ev_handle !== '0) begin
      mismatched++;
      $display("[TB] FAIL async_abort: ov=%0b busy=%0b cnt=%0d done=%0b evh=%0d want 0 0 0 0 0",
               out_valid, busy, match_count, done, ev_handle);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++;
    if (req_ready !== 1'b1) begin
      mismatched++; $display("[TB] FAIL abort_release_ready: got %0b want 1", req_ready);
    end
    for (int i = 0; i < N; i++) begin mEltDef[i] = 0; mIsMeta[i] = 0; mMeta[i] = 0; end
    lastCount = 0;
    run_scan(8'd5, 8'd1, 8'd2, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; cell_we = 1'b0; cell_addr = '0; cell_elt_def = 1'b0; cell_is_meta = 1'b0;
    cell_meta = '0; req_valid = 1'b0; req_handle = '0; req_low = '0; req_high = '0; out_ready = 1'b0;
    test_reset();
    test_no_match();
    test_single_match();
    test_backpressure();
    test_all_match();
    test_write_while_busy();
    test_random();
    test_reset_mid_emit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
